// File: rtl/led_matrix_scan.sv
// Row-multiplexed scan driver for the LED dot matrix: snapshots the frame once per scan,
// then lights one row at a time with an optional blanking gap before each row.
//   state   | meaning
//   S_IDLE  | dark, waiting for enable
//   S_LOAD  | snapshot frame, pulse frame_start
//   S_BLANK | all rows off before the next row
//   S_SHOW  | drive row_sel/col_data for row_index
module led_matrix_scan #(
  parameter int ROWS  = 12,
  parameter int COLS  = 16,
  parameter int DWELL = 5000,
  parameter int BLANK = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_data,
  output logic [3:0]           row_index,
  output logic                 frame_start,
  output logic                 scanning
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [3:0]    LAST_ROW = 4'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BLANK, S_SHOW} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [COLS-1:0] r_buf [ROWS];
  logic [ROWS-1:0] r_sel;
  logic [COLS-1:0] r_col;
  logic [3:0]      r_row;
  logic            r_fs;
  logic            r_scan;

  logic [3:0]      w_next_row;
  logic [ROWS-1:0] w_next_sel;

  assign w_next_row = r_row + 4'd1;
  assign w_next_sel = ROWS'(1) << w_next_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_fs    <= 1'b0;
      r_scan  <= 1'b0;
      for (int r = 0; r < ROWS; r++) r_buf[r] <= '0;
    end else if (!enable) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_fs    <= 1'b0;
      r_scan  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_LOAD;
          r_fs    <= 1'b1;
          r_scan  <= 1'b1;
          r_row   <= '0;
        end
        S_LOAD: begin
          r_fs  <= 1'b0;
          r_row <= '0;
          for (int r = 0; r < ROWS; r++) r_buf[r] <= frame[ROWS*COLS-1-COLS*r -: COLS];
          if (BLANK == 0) begin
            // Buffer is written on this same edge, so row 0 comes straight from the frame.
            r_state <= S_SHOW;
            r_cnt   <= DWELL_LD;
            r_sel   <= ROWS'(1);
            r_col   <= frame[ROWS*COLS-1 -: COLS];
          end else begin
            r_state <= S_BLANK;
            r_cnt   <= BLANK_LD;
          end
        end
        S_BLANK: begin
          if (r_cnt == '0) begin
            r_state <= S_SHOW;
            r_cnt   <= DWELL_LD;
            r_sel   <= ROWS'(1) << r_row;
            r_col   <= r_buf[r_row];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SHOW: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_row == LAST_ROW) begin
            r_state <= S_LOAD;
            r_fs    <= 1'b1;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_col   <= '0;
            r_row   <= '0;
          end else begin
            r_row <= w_next_row;
            if (BLANK == 0) begin
              r_state <= S_SHOW;
              r_cnt   <= DWELL_LD;
              r_sel   <= w_next_sel;
              r_col   <= r_buf[w_next_row];
            end else begin
              r_state <= S_BLANK;
              r_cnt   <= BLANK_LD;
              r_sel   <= '0;
              r_col   <= '0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= '0;
          r_col   <= '0;
          r_scan  <= 1'b0;
        end
      endcase
    end
  end

  assign row_sel     = r_sel;
  assign col_data    = r_col;
  assign row_index   = r_row;
  assign frame_start = r_fs;
  assign scanning    = r_scan;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: one instance with DWELL=4/BLANK=2,
// a second with DWELL=1/BLANK=0 for back-to-back row walking.
module tb_led_matrix_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, en_a, en_b;
  logic [191:0] frame_a, frame_b;
  logic [11:0]  sel_a, sel_b;
  logic [15:0]  col_a, col_b;
  logic [3:0]   ridx_a, ridx_b;
  logic         fs_a, fs_b, scan_a, scan_b;

  led_matrix_scan #(.ROWS(12), .COLS(16), .DWELL(4), .BLANK(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .frame(frame_a),
    .row_sel(sel_a), .col_data(col_a), .row_index(ridx_a),
    .frame_start(fs_a), .scanning(scan_a)
  );

  led_matrix_scan #(.ROWS(12), .COLS(16), .DWELL(1), .BLANK(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .frame(frame_b),
    .row_sel(sel_b), .col_data(col_b), .row_index(ridx_b),
    .frame_start(fs_b), .scanning(scan_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fs_a(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!fs_a && n < 200);
  endtask

  // Row drive must be one-hot or zero, and columns dark whenever no row is driven.
  logic w_ok_a, w_ok_b;
  assign w_ok_a = $onehot0(sel_a) && ((sel_a != '0) || (col_a == '0));
  assign w_ok_b = $onehot0(sel_b) && ((sel_b != '0) || (col_b == '0));

  always @(negedge clk) begin
    check("onehot_a", {31'd0, w_ok_a}, 32'd1);
    check("onehot_b", {31'd0, w_ok_b}, 32'd1);
  end

  logic [191:0] f1, f2, f3;
  int n;

  initial begin
    f1 = '0;
    f1[191:176] = 16'hFFFF;
    f1[111:96]  = 16'h0001;
    f2 = {12{16'hA5A5}};
    f3 = '0;
    for (int r = 0; r < 12; r++) f3[191-16*r -: 16] = 16'((r + 1) * 16'h0101);

    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    frame_a = f1; frame_b = f3;
    step(2);
    check("rst_sel",  {20'd0, sel_a}, 32'h0);
    check("rst_col",  {16'd0, col_a}, 32'h0);
    check("rst_ridx", {28'd0, ridx_a}, 32'h0);
    check("rst_fs",   {31'd0, fs_a}, 32'h0);
    check("rst_scan", {31'd0, scan_a}, 32'h0);

    // Get into SHOW of row 0, then reset asynchronously mid-row
    rst_n = 1'b1; en_a = 1'b1;
    step(1);
    check("pre_fs",   {31'd0, fs_a}, 32'h1);
    check("pre_scan", {31'd0, scan_a}, 32'h1);
    step(3);
    check("pre_sel",  {20'd0, sel_a}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_sel",  {20'd0, sel_a}, 32'h0);
    check("arst_col",  {16'd0, col_a}, 32'h0);
    check("arst_scan", {31'd0, scan_a}, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("fs_cycle1", {31'd0, fs_a}, 32'h1);

    // Frame f1 scan, k=0 is the LOAD cycle
    step(1);
    check("k1_sel",  {20'd0, sel_a}, 32'h0);
    check("k1_col",  {16'd0, col_a}, 32'h0);
    check("k1_ridx", {28'd0, ridx_a}, 32'h0);
    check("k1_fs",   {31'd0, fs_a}, 32'h0);
    step(2);
    check("row0_sel", {20'd0, sel_a}, 32'h001);
    check("row0_col", {16'd0, col_a}, 32'hFFFF);
    step(3);
    check("row0_last_col", {16'd0, col_a}, 32'hFFFF);
    step(1);
    check("blank1_sel",  {20'd0, sel_a}, 32'h0);
    check("blank1_ridx", {28'd0, ridx_a}, 32'h1);
    step(2);
    check("row1_sel", {20'd0, sel_a}, 32'h002);
    check("row1_col", {16'd0, col_a}, 32'h0);
    step(24);
    check("row5_sel",  {20'd0, sel_a}, 32'h020);
    check("row5_col",  {16'd0, col_a}, 32'h0001);
    check("row5_ridx", {28'd0, ridx_a}, 32'h5);
    wait_fs_a(n);
    check("period", 32'(n + 33), 32'd73);

    // Change frame during row 3: rows 4.. keep showing the snapshot
    step(21);
    check("row3_sel", {20'd0, sel_a}, 32'h008);
    frame_a = f2;
    step(6);
    check("old_row4_sel", {20'd0, sel_a}, 32'h010);
    check("old_row4_col", {16'd0, col_a}, 32'h0);
    step(6);
    check("old_row5_col", {16'd0, col_a}, 32'h0001);
    wait_fs_a(n);
    check("period2", 32'(n + 33), 32'd73);
    step(27);
    check("new_row4_sel", {20'd0, sel_a}, 32'h010);
    check("new_row4_col", {16'd0, col_a}, 32'hA5A5);

    // Drop enable during blanking of row 7
    step(16);
    check("blank7_ridx", {28'd0, ridx_a}, 32'h7);
    check("blank7_sel",  {20'd0, sel_a}, 32'h0);
    en_a = 1'b0;
    step(1);
    check("dis_sel",  {20'd0, sel_a}, 32'h0);
    check("dis_scan", {31'd0, scan_a}, 32'h0);
    check("dis_ridx", {28'd0, ridx_a}, 32'h0);
    step(2);
    check("idle_scan", {31'd0, scan_a}, 32'h0);
    en_a = 1'b1;
    step(1);
    check("reen_fs",   {31'd0, fs_a}, 32'h1);
    check("reen_ridx", {28'd0, ridx_a}, 32'h0);
    step(3);
    check("reen_sel",  {20'd0, sel_a}, 32'h001);
    check("reen_col",  {16'd0, col_a}, 32'hA5A5);
    check("reen_ridx0", {28'd0, ridx_a}, 32'h0);

    // No blanking, single-clock dwell: row walk on consecutive clocks
    en_b = 1'b1;
    step(1);
    check("b_fs", {31'd0, fs_b}, 32'h1);
    for (int r = 0; r < 12; r++) begin
      step(1);
      check("b_walk_sel",  {20'd0, sel_b}, 32'h1 << r);
      check("b_walk_col",  {16'd0, col_b}, 32'((r + 1) * 32'h0101));
      check("b_walk_ridx", {28'd0, ridx_b}, 32'(r));
    end
    step(1);
    check("b_period_fs",  {31'd0, fs_b}, 32'h1);
    check("b_period_sel", {20'd0, sel_b}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
